// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write controller.
// LCD_INIT_EN adds the power-up wait and built-in init states.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
`ifdef LCD_INIT_EN
      ST_WAIT,
      ST_PWRUP,
      ST_INIT
`else
      ST_WAIT
`endif
   } lcd_state_e;

   localparam int LCD_ON_BIT = 31;
   localparam int LCD_GO_BIT = 10;
   localparam int LCD_RS_BIT = 9;

   // function set 8-bit/2-line, display on, clear, entry mode increment
   localparam logic [7:0] LCD_INIT_SEQ [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
   function automatic logic is_clr_home(input logic rs, input logic [7:0] data);
      return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
   endfunction

   function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed FSM state; holds at zero.
module lcd_timer #(
   parameter int             W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o
);

   // Load takes priority; otherwise count down and stop at zero.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         cnt_o <= RST_VAL;
      else if (load_i)
         cnt_o <= val_i;
      else if (cnt_o != '0)
         cnt_o <= cnt_o - 1'b1;
   end

   assign zero_o = (cnt_o == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: turns GO toggles on io_lcd into timed bus writes,
// with a one-deep pending slot. Define LCD_INIT_EN for the built-in
// power-up wait and init command sequence.
//
// state | meaning
// PWRUP | post-reset wait before first access (LCD_INIT_EN only)
// INIT  | fetch next init ROM command (LCD_INIT_EN only)
// IDLE  | no access in progress, RS/DATA hold last value
// SETUP | RS/DATA valid, EN low
// PULSE | EN high
// HOLD  | EN low, RS/DATA held
// WAIT  | LCD execution time (long for clear/home)
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP_CYC = 2,
   parameter int unsigned T_EN_CYC    = 12,
   parameter int unsigned T_HOLD_CYC  = 2,
   parameter int unsigned T_EXEC_CYC  = 2000,
   parameter int unsigned T_CLR_CYC   = 82000,
   parameter int unsigned T_PWRUP_CYC = 750000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] io_lcd_i,
   output logic [7:0]  lcd_data_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic        lcd_on_o,
   output logic        busy_o,
   output logic        ovf_o
);

   localparam int unsigned T_MAX = max_cyc(max_cyc(max_cyc(T_SETUP_CYC, T_EN_CYC),
                                                   max_cyc(T_HOLD_CYC, T_EXEC_CYC)),
                                           max_cyc(T_CLR_CYC, T_PWRUP_CYC));
   localparam int TW = $clog2(T_MAX) + 1;

`ifdef LCD_INIT_EN
   localparam lcd_state_e    RST_STATE = ST_PWRUP;
   localparam logic [TW-1:0] RST_CNT   = TW'(T_PWRUP_CYC - 1);
`else
   localparam lcd_state_e    RST_STATE = ST_IDLE;
   localparam logic [TW-1:0] RST_CNT   = '0;
`endif

   lcd_state_e    state_q, state_d;
   logic          go_q;
   logic          evt;
   logic [8:0]    evt_cmd;
   logic [8:0]    cmd_q, cmd_d;
   logic          pend_vld_q;
   logic [8:0]    pend_cmd_q;
   logic          pend_take;
   logic          evt_to_slot;
   logic          ovf_set;
   logic          ovf_q;
   logic          on_q;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_zero;
   logic [TW-1:0] unused_tmr_cnt;
   logic          unused_io;
`ifdef LCD_INIT_EN
   logic [2:0]    init_idx_q;
   logic          init_step;
`endif

   assign evt       = io_lcd_i[LCD_GO_BIT] ^ go_q;
   assign evt_cmd   = {io_lcd_i[LCD_RS_BIT], io_lcd_i[7:0]};
   assign unused_io = ^{io_lcd_i[30:11], io_lcd_i[8]};

   lcd_timer #(.W(TW), .RST_VAL(RST_CNT)) u_timer (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (tmr_load),
      .val_i   (tmr_val),
      .cnt_o   (unused_tmr_cnt),
      .zero_o  (tmr_zero)
   );

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         state_q <= RST_STATE;
      else
         state_q <= state_d;
   end

   // Next state, timer loads, command selection and pending-slot control.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      pend_take = 1'b0;
`ifdef LCD_INIT_EN
      init_step = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pend_vld_q || evt) begin
               cmd_d     = pend_vld_q ? pend_cmd_q : evt_cmd;
               pend_take = pend_vld_q;
               state_d   = ST_SETUP;
               tmr_load  = 1'b1;
               tmr_val   = TW'(T_SETUP_CYC - 1);
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = TW'(T_EN_CYC - 1);
            end
         end
         ST_PULSE: begin
            if (tmr_zero) begin
               state_d  = ST_HOLD;
               tmr_load = 1'b1;
               tmr_val  = TW'(T_HOLD_CYC - 1);
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               state_d  = ST_WAIT;
               tmr_load = 1'b1;
               tmr_val  = is_clr_home(cmd_q[8], cmd_q[7:0]) ? TW'(T_CLR_CYC - 1)
                                                            : TW'(T_EXEC_CYC - 1);
            end
         end
         ST_WAIT: begin
            if (tmr_zero) begin
`ifdef LCD_INIT_EN
               state_d = (init_idx_q != 3'd4) ? ST_INIT : ST_IDLE;
`else
               state_d = ST_IDLE;
`endif
            end
         end
`ifdef LCD_INIT_EN
         ST_PWRUP: begin
            if (tmr_zero)
               state_d = ST_INIT;
         end
         ST_INIT: begin
            cmd_d     = {1'b0, LCD_INIT_SEQ[init_idx_q[1:0]]};
            init_step = 1'b1;
            state_d   = ST_SETUP;
            tmr_load  = 1'b1;
            tmr_val   = TW'(T_SETUP_CYC - 1);
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      // An event goes to the slot unless IDLE consumes it directly.
      evt_to_slot = evt && !(state_q == ST_IDLE && !pend_vld_q);
      ovf_set     = evt_to_slot && pend_vld_q && !pend_take;
   end

   // Datapath: command, pending slot, overflow, GO edge history, panel power.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         go_q       <= 1'b0;
         cmd_q      <= '0;
         pend_vld_q <= 1'b0;
         pend_cmd_q <= '0;
         ovf_q      <= 1'b0;
         on_q       <= 1'b0;
`ifdef LCD_INIT_EN
         init_idx_q <= '0;
`endif
      end else begin
         go_q  <= io_lcd_i[LCD_GO_BIT];
         on_q  <= io_lcd_i[LCD_ON_BIT];
         cmd_q <= cmd_d;
         if (evt_to_slot) begin
            pend_vld_q <= 1'b1;
            pend_cmd_q <= evt_cmd;
         end else if (pend_take) begin
            pend_vld_q <= 1'b0;
         end
         if (ovf_set)
            ovf_q <= 1'b1;
`ifdef LCD_INIT_EN
         if (init_step)
            init_idx_q <= init_idx_q + 3'd1;
`endif
      end
   end

   assign lcd_data_o = cmd_q[7:0];
   assign lcd_rs_o   = cmd_q[8];
   assign lcd_rw_o   = 1'b0;
   assign lcd_en_o   = (state_q == ST_PULSE);
   assign lcd_on_o   = on_q;
   assign busy_o     = (state_q != ST_IDLE) || pend_vld_q;
   assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with short sim timing parameters.
module tb_lcd_ctrl;

   localparam int T_SETUP = 2;
   localparam int T_EN    = 3;
   localparam int T_HOLD  = 1;
   localparam int T_EXEC  = 5;
   localparam int T_CLR   = 9;
   localparam int T_PWRUP = 10;

`ifdef LCD_INIT_EN
   localparam logic RST_BUSY = 1'b1;
`else
   localparam logic RST_BUSY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] io = '0;
   logic [7:0]  lcd_data;
   logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, ovf;

   int total = 0;
   int bad   = 0;

   logic [7:0] rise_data[$];
   logic       rise_rs[$];
   int         rise_k[$];

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         wait_cyc;
   } vec_t;

   vec_t vecs[7];

   lcd_ctrl #(
      .T_SETUP_CYC (T_SETUP),
      .T_EN_CYC    (T_EN),
      .T_HOLD_CYC  (T_HOLD),
      .T_EXEC_CYC  (T_EXEC),
      .T_CLR_CYC   (T_CLR),
      .T_PWRUP_CYC (T_PWRUP)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .io_lcd_i   (io),
      .lcd_data_o (lcd_data),
      .lcd_rs_o   (lcd_rs),
      .lcd_rw_o   (lcd_rw),
      .lcd_en_o   (lcd_en),
      .lcd_on_o   (lcd_on),
      .busy_o     (busy),
      .ovf_o      (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Toggle GO with a new command on a falling edge; the next rising edge sees the event.
   task automatic send(input logic rs, input logic [7:0] data);
      @(negedge clk);
      io[10]  = ~io[10];
      io[9]   = rs;
      io[7:0] = data;
   endtask

   // Record every EN rising edge (data, rs, cycle index) over ncyc cycles.
   task automatic collect(input int ncyc);
      logic prev;
      rise_data.delete();
      rise_rs.delete();
      rise_k.delete();
      prev = lcd_en;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (lcd_en && !prev) begin
            rise_data.push_back(lcd_data);
            rise_rs.push_back(lcd_rs);
            rise_k.push_back(k);
         end
         prev = lcd_en;
      end
   endtask

   // Follow one access from its event edge until busy drops.
   task automatic measure(input int idx, input logic rs, input logic [7:0] data, input int wait_cyc);
      int first = -1;
      int last  = -1;
      int idle  = -1;
      logic [7:0] d_seen = '0;
      logic       rs_seen = 1'b0;
      logic       ovf_seen = 1'b0;
      for (int k = 0; k < 60 && idle < 0; k++) begin
         @(negedge clk);
         if (lcd_en) begin
            if (first < 0) begin
               first   = k;
               d_seen  = lcd_data;
               rs_seen = lcd_rs;
            end
            last = k;
         end
         if (ovf) ovf_seen = 1'b1;
         if (!busy) idle = k;
      end
      check($sformatf("vec%0d_en_first", idx), first, T_SETUP);
      check($sformatf("vec%0d_en_last", idx), last, T_SETUP + T_EN - 1);
      check($sformatf("vec%0d_data", idx), d_seen, data);
      check($sformatf("vec%0d_rs", idx), rs_seen, rs);
      check($sformatf("vec%0d_idle_cycle", idx), idle, T_SETUP + T_EN + T_HOLD + wait_cyc);
      check($sformatf("vec%0d_ovf", idx), ovf_seen, 1'b0);
      check($sformatf("vec%0d_rw", idx), lcd_rw, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 8'h41, T_EXEC};
      vecs[1] = '{1'b0, 8'h01, T_CLR};
      vecs[2] = '{1'b0, 8'h08, T_EXEC};
      vecs[3] = '{1'b0, 8'h02, T_CLR};
      vecs[4] = '{1'b0, 8'h03, T_CLR};
      vecs[5] = '{1'b0, 8'h04, T_EXEC};
      vecs[6] = '{1'b0, 8'h00, T_EXEC};

      rst_n = 1'b0;
      io    = '0;
      repeat (3) @(negedge clk);
      check("rst_en", lcd_en, 1'b0);
      check("rst_busy", busy, RST_BUSY);
      check("rst_ovf", ovf, 1'b0);
      check("rst_data", lcd_data, 8'h00);
      check("rst_rs", lcd_rs, 1'b0);
      check("rst_on", lcd_on, 1'b0);
      rst_n = 1'b1;

`ifdef LCD_INIT_EN
      collect(150);
      check("init_count", rise_data.size(), 4);
      if (rise_data.size() == 4) begin
         check("init_first_k", rise_k[0], 12);
         check("init_d0", rise_data[0], 8'h38);
         check("init_d1", rise_data[1], 8'h0C);
         check("init_d2", rise_data[2], 8'h01);
         check("init_d3", rise_data[3], 8'h06);
         check("init_rs", {rise_rs[0], rise_rs[1], rise_rs[2], rise_rs[3]}, 4'b0000);
      end
      check("init_busy_done", busy, 1'b0);
`endif

      // panel power follows ON with one cycle of latency
      @(negedge clk);
      io[31] = 1'b1;
      #1 check("on_latency0", lcd_on, 1'b0);
      @(negedge clk);
      check("on_latency1", lcd_on, 1'b1);

      for (int i = 0; i < 7; i++) begin
         send(vecs[i].rs, vecs[i].data);
         measure(i, vecs[i].rs, vecs[i].data, vecs[i].wait_cyc);
      end

      // two identical characters back to back are two writes
      send(1'b1, 8'h42);
      send(1'b1, 8'h42);
      collect(60);
      check("dup_count", rise_data.size(), 2);
      if (rise_data.size() == 2) begin
         check("dup_d0", rise_data[0], 8'h42);
         check("dup_d1", rise_data[1], 8'h42);
      end
      check("dup_ovf", ovf, 1'b0);
      check("dup_busy", busy, 1'b0);

      // three events during one access: last pending wins, overflow sticks
      send(1'b1, 8'h31);
      send(1'b1, 8'h32);
      send(1'b1, 8'h33);
      collect(60);
      check("ovw_count", rise_data.size(), 2);
      if (rise_data.size() == 2) begin
         check("ovw_d0", rise_data[0], 8'h31);
         check("ovw_d1", rise_data[1], 8'h33);
      end
      check("ovw_ovf", ovf, 1'b1);

      // reset during PULSE with a pending command and overflow set
      send(1'b1, 8'h55);
      send(1'b1, 8'h66);
      send(1'b1, 8'h77);
      @(negedge clk);
      check("rstp_en_before", lcd_en, 1'b1);
      check("rstp_ovf_before", ovf, 1'b1);
      #2;
      rst_n  = 1'b0;
      io[10] = 1'b0;
      #1;
      check("rstp_en", lcd_en, 1'b0);
      check("rstp_busy", busy, RST_BUSY);
      check("rstp_ovf", ovf, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef LCD_INIT_EN
      collect(150);
      check("rstp_rises", rise_data.size(), 4);
      if (rise_data.size() > 0)
         check("rstp_first", rise_data[0], 8'h38);
`else
      collect(40);
      check("rstp_rises", rise_data.size(), 0);
`endif
      check("rstp_busy_end", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
